// File: rtl/reg_alu_pipe.sv
// Register file + ALU with a 2-stage EX/WB pipeline, WB->EX forwarding, load stall on mem_valid
// and a registered PSR {C,L,F,Z,N}.
`timescale 1ns/1ps
module reg_alu_pipe #(
  parameter int unsigned DW      = 16,
  parameter int unsigned NREG    = 16,
  parameter int unsigned IMMW    = 8,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     write_i,
  input  logic                     imm_mux_i,
  input  logic [1:0]               wb_mux_i,
  input  logic [$clog2(NREG)-1:0]  r_src_i,
  input  logic [$clog2(NREG)-1:0]  r_dst_i,
  input  logic [4:0]               alu_op_i,
  input  logic [IMMW-1:0]          imm_in_i,
  input  logic [DW-1:0]            pc_ra_i,
  input  logic [DW-1:0]            mem_data_i,
  input  logic                     mem_valid_i,
  output logic [DW-1:0]            d_src_o,
  output logic [DW-1:0]            d_dst_o,
  output logic [DW-1:0]            alu_result_o,
  output logic [4:0]               psr_out_o
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(DW);
  localparam logic [DW-1:0] DW_VAL = DW'(DW);

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_CMP = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_XOR = 5'd5;
  localparam logic [4:0] ALU_MOV = 5'd6;
  localparam logic [4:0] ALU_LUI = 5'd7;
  localparam logic [4:0] ALU_SLL = 5'd8;
  localparam logic [4:0] ALU_SRL = 5'd9;
  localparam logic [4:0] ALU_SRA = 5'd10;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [4:0]    psr_q, psr_d;
  logic          wb_valid_q;
  logic          wb_write_q, wb_write_d;
  logic [AW-1:0] wb_dst_q;

  logic          accept;
  logic          is_arith;
  logic [DW-1:0] b_ext, a_op, b_op, alu_res;
  logic [DW:0]   sum, diff;
  logic          ovf_add, ovf_sub, shift_big;
  logic [SW-1:0] shamt;

  // A load without data holds the op in EX; reset always presents a ready issue port
  assign in_ready_o = rst | ~(in_valid_i & (wb_mux_i == 2'b10) & ~mem_valid_i);
  assign accept     = in_valid_i & in_ready_o;

  // Operand read with forwarding of the pending WB value; r0 reads zero when hardwired
  always_comb begin
    d_src_o = regs_q[r_src_i];
    d_dst_o = regs_q[r_dst_i];
    if (wb_valid_q && wb_write_q && (wb_dst_q == r_src_i)) d_src_o = alu_result_q;
    if (wb_valid_q && wb_write_q && (wb_dst_q == r_dst_i)) d_dst_o = alu_result_q;
    if (R0_ZERO && (r_src_i == '0)) d_src_o = '0;
    if (R0_ZERO && (r_dst_i == '0)) d_dst_o = '0;
  end

  assign is_arith = (alu_op_i == ALU_ADD) || (alu_op_i == ALU_SUB) || (alu_op_i == ALU_CMP);

  always_comb begin
    b_ext = is_arith ? {{(DW-IMMW){imm_in_i[IMMW-1]}}, imm_in_i}
                     : {{(DW-IMMW){1'b0}}, imm_in_i};
    a_op  = d_dst_o;
    b_op  = imm_mux_i ? b_ext : d_src_o;
    sum   = {1'b0, a_op} + {1'b0, b_op};
    diff  = {1'b0, a_op} - {1'b0, b_op};
    ovf_add = (a_op[DW-1] == b_op[DW-1]) && (sum[DW-1] != a_op[DW-1]);
    ovf_sub = (a_op[DW-1] != b_op[DW-1]) && (diff[DW-1] != a_op[DW-1]);
    shamt     = b_op[SW-1:0];
    shift_big = (b_op >= DW_VAL);
    alu_res   = '0;
    psr_d     = psr_q;
    case (alu_op_i)
      ALU_ADD: begin
        alu_res = sum[DW-1:0];
        psr_d   = {sum[DW], 1'b0, ovf_add, (sum[DW-1:0] == '0), sum[DW-1]};
      end
      ALU_SUB: begin
        alu_res = diff[DW-1:0];
        psr_d   = {diff[DW], 1'b0, ovf_sub, (diff[DW-1:0] == '0), diff[DW-1]};
      end
      ALU_CMP: begin
        // N reports signed less-than, so correct the sign bit by the overflow
        alu_res = diff[DW-1:0];
        psr_d   = {diff[DW], diff[DW], ovf_sub, (a_op == b_op), diff[DW-1] ^ ovf_sub};
      end
      ALU_AND: alu_res = a_op & b_op;
      ALU_OR:  alu_res = a_op | b_op;
      ALU_XOR: alu_res = a_op ^ b_op;
      ALU_MOV: alu_res = b_op;
      ALU_LUI: alu_res = {imm_in_i, {(DW-IMMW){1'b0}}};
      ALU_SLL: alu_res = shift_big ? '0 : (a_op << shamt);
      ALU_SRL: alu_res = shift_big ? '0 : (a_op >> shamt);
      ALU_SRA: alu_res = shift_big ? {DW{a_op[DW-1]}} : $unsigned($signed(a_op) >>> shamt);
      default: alu_res = '0;
    endcase
    case (wb_mux_i)
      2'b01:   alu_result_d = pc_ra_i;
      2'b10:   alu_result_d = mem_data_i;
      default: alu_result_d = alu_res;
    endcase
    wb_write_d = write_i && (alu_op_i != ALU_CMP) && !(R0_ZERO && (r_dst_i == '0));
  end

  // EX/WB stage, flags and register file writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q <= '0;
      psr_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_write_q   <= 1'b0;
      wb_dst_q     <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      if (wb_valid_q && wb_write_q) regs_q[wb_dst_q] <= alu_result_q;
      wb_valid_q <= accept;
      if (accept) begin
        alu_result_q <= alu_result_d;
        psr_q        <= psr_d;
        wb_write_q   <= wb_write_d;
        wb_dst_q     <= r_dst_i;
      end
    end
  end

  assign alu_result_o = alu_result_q;
  assign psr_out_o    = psr_q;
endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed + random bench for reg_alu_pipe against an architectural (unpipelined) model.
`timescale 1ns/1ps
module tb_reg_alu_pipe;
  localparam int unsigned DW = 16, NREG = 16, IMMW = 8, AW = 4;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, CMP = 5'd2, AND_ = 5'd3, OR_ = 5'd4,
                         XOR_ = 5'd5, MOV = 5'd6, LUI = 5'd7, SLL = 5'd8, SRL = 5'd9,
                         SRA = 5'd10;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, write = 1'b0, imm_mux = 1'b0, mem_valid = 1'b0;
  logic [1:0] wb_mux = 2'b00;
  logic [AW-1:0] r_src = '0, r_dst = '0;
  logic [4:0] alu_op = 5'd0;
  logic [IMMW-1:0] imm_in = '0;
  logic [DW-1:0] pc_ra = '0, mem_data = '0, d_src, d_dst, alu_result;
  logic [4:0] psr_out;

  int vectors = 0, miscompares = 0;
  int mregs [NREG];
  int mres;
  logic [4:0] mpsr;

  reg_alu_pipe #(.DW(DW), .NREG(NREG), .IMMW(IMMW), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .write_i(write),
    .imm_mux_i(imm_mux), .wb_mux_i(wb_mux), .r_src_i(r_src), .r_dst_i(r_dst),
    .alu_op_i(alu_op), .imm_in_i(imm_in), .pc_ra_i(pc_ra), .mem_data_i(mem_data),
    .mem_valid_i(mem_valid), .d_src_o(d_src), .d_dst_o(d_dst), .alu_result_o(alu_result),
    .psr_out_o(psr_out));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mread(input int idx);
    return (idx == 0) ? 0 : mregs[idx];
  endfunction

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Architectural effect of one accepted op: regs visible immediately, flags per rules
  task automatic model_exec(input logic [4:0] op, input int dst, input int src, input bit immm,
                            input int imm, input int wbm, input bit wr, input int pc, input int md);
    int a, b, r, sa, sb, s;
    bit c, l, f, z, n, arith;
    arith = (op == ADD) || (op == SUB) || (op == CMP);
    a = mread(dst);
    if (immm) b = (arith && imm >= 128) ? imm + 32'hFF00 : imm;
    else      b = mread(src);
    sa = to_signed(a);
    sb = to_signed(b);
    r = 0; c = 0; l = 0; f = 0;
    case (op)
      ADD: begin s = a + b; r = s % 65536; c = (s >= 65536); s = sa + sb; f = (s > 32767 || s < -32768); end
      SUB, CMP: begin r = (a - b + 65536) % 65536; c = (a < b); s = sa - sb; f = (s > 32767 || s < -32768); end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      MOV:  r = b;
      LUI:  r = imm * 256;
      SLL:  r = (b >= 16) ? 0 : (a << b) % 65536;
      SRL:  r = (b >= 16) ? 0 : a >> b;
      SRA:  r = (b >= 16) ? ((a >= 32768) ? 65535 : 0) : ((sa >>> b) & 32'hFFFF);
      default: r = 0;
    endcase
    z = (r == 0);
    n = (r >= 32768);
    if (op == CMP) begin z = (a == b); l = (a < b); n = (sa < sb); end
    if (arith) mpsr = {c, l, f, z, n};
    mres = (wbm == 1) ? pc : (wbm == 2) ? md : r;
    if (wr && op != CMP && dst != 0) mregs[dst] = mres;
  endtask

  // Entered just after a rising edge; leaves just after the edge that accepts the op
  task automatic issue(input string tag, input logic [4:0] op, input int dst, input int src,
                       input bit immm, input int imm, input int wbm, input bit wr,
                       input int pc, input int md, input int lat);
    int stall;
    stall = (wbm == 2) ? lat : 0;
    in_valid = 1'b1; alu_op = op; r_dst = AW'(dst); r_src = AW'(src); imm_mux = immm;
    imm_in = IMMW'(imm); wb_mux = 2'(wbm); write = wr; pc_ra = DW'(pc);
    mem_valid = (stall == 0); mem_data = (stall == 0) ? DW'(md) : DW'($urandom);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_stall_hold"}, 32'(alu_result), 32'(mres));
      check({tag, "_stall_psr"}, 32'(psr_out), 32'(mpsr));
    end
    mem_valid = 1'b1; mem_data = DW'(md);
    @(negedge clk);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_d_dst"}, 32'(d_dst), 32'(mread(dst)));
    check({tag, "_d_src"}, 32'(d_src), 32'(mread(src)));
    model_exec(op, dst, src, immm, imm, wbm, wr, pc, md);
    @(posedge clk); #1;
    check({tag, "_result"}, 32'(alu_result), 32'(mres));
    check({tag, "_psr"}, 32'(psr_out), 32'(mpsr));
  endtask

  task automatic bubble();
    in_valid = 1'b0; wb_mux = 2'($urandom_range(0, 3)); alu_op = 5'($urandom_range(0, 10));
    r_src = AW'($urandom); r_dst = AW'($urandom); mem_valid = 1'($urandom);
    @(negedge clk);
    check("bubble_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bubble_hold", 32'(alu_result), 32'(mres));
    check("bubble_psr", 32'(psr_out), 32'(mpsr));
  endtask

  initial begin
    for (int i = 0; i < int'(NREG); i++) mregs[i] = 0;
    mres = 0; mpsr = 5'd0;
    #2;
    check("rst_result", 32'(alu_result), 32'd0);
    check("rst_psr", 32'(psr_out), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    issue("mov_r1_r0", MOV, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    issue("add_r0", ADD, 0, 0, 1, 5, 0, 1, 0, 0, 0);
    issue("read_r0", MOV, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    check("r0_zero", 32'(alu_result), 32'd0);
    issue("addi_10", ADD, 1, 0, 1, 10, 0, 1, 0, 0, 0);
    issue("addi_m3", ADD, 1, 0, 1, 8'hFD, 0, 1, 0, 0, 0);
    check("addi_fwd_val", 32'(alu_result), 32'd7);
    check("addi_flags", 32'(psr_out), 32'b10000);
    issue("lui_r2", LUI, 2, 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    check("lui_val", 32'(alu_result), 32'hFF00);
    issue("lui_r3", LUI, 3, 0, 1, 8'h7F, 0, 1, 0, 0, 0);
    issue("ori_r3", OR_, 3, 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    issue("ovf_r3", ADD, 3, 0, 1, 1, 0, 1, 0, 0, 0);
    check("ovf_val", 32'(alu_result), 32'h8000);
    check("ovf_flags", 32'(psr_out), 32'b00101);
    issue("load_r3", MOV, 3, 0, 0, 0, 2, 1, 0, 16'h000A, 3);
    check("load_val", 32'(alu_result), 32'h000A);
    issue("movi_r1", MOV, 1, 0, 1, 10, 0, 1, 0, 0, 0);
    issue("cmp_eq", CMP, 1, 3, 0, 0, 0, 1, 0, 0, 0);
    check("cmp_eq_flags", 32'(psr_out), 32'b00010);
    issue("cmp_nowb", MOV, 8, 1, 0, 0, 0, 1, 0, 0, 0);
    check("cmp_nowb_val", 32'(alu_result), 32'd10);
    issue("movi_r5", MOV, 5, 0, 1, 1, 0, 1, 0, 0, 0);
    issue("addi_r6", ADD, 6, 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    issue("cmp_lt", CMP, 5, 6, 0, 0, 0, 0, 0, 0, 0);
    check("cmp_lt_flags", 32'(psr_out), 32'b11000);
    issue("movi_r4", MOV, 4, 0, 1, 1, 0, 1, 0, 0, 0);
    issue("sll15", SLL, 4, 0, 1, 15, 0, 1, 0, 0, 0);
    check("sll15_val", 32'(alu_result), 32'h8000);
    issue("sra15", SRA, 4, 0, 1, 15, 0, 1, 0, 0, 0);
    check("sra15_val", 32'(alu_result), 32'hFFFF);
    issue("movi_r7", MOV, 7, 0, 1, 16, 0, 1, 0, 0, 0);
    issue("srl16", SRL, 4, 7, 0, 0, 0, 1, 0, 0, 0);
    check("srl16_val", 32'(alu_result), 32'h0000);
    issue("link_r9", ADD, 9, 1, 0, 0, 1, 1, 16'h1234, 0, 0);
    bubble();

    // Reset in the middle of a load stall
    in_valid = 1'b1; wb_mux = 2'b10; mem_valid = 1'b0; r_dst = 4'd3; r_src = 4'd1;
    alu_op = MOV; write = 1'b1;
    @(negedge clk);
    check("midstall_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; #1;
    check("rst_stall_ready", 32'(in_ready), 32'd1);
    check("rst_stall_result", 32'(alu_result), 32'd0);
    check("rst_stall_psr", 32'(psr_out), 32'd0);
    check("rst_stall_r3", 32'(d_dst), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < int'(NREG); i++) mregs[i] = 0;
    mres = 0; mpsr = 5'd0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue("post_rst", MOV, 3, 1, 0, 0, 0, 1, 0, 0, 0);

    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 7) == 0) bubble();
      else issue("rand", 5'($urandom_range(0, 10)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
    end
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
